// File: rtl/riscv_stream_pkg.sv
// Shared definitions for the PicoRV32 stream I/O bridge: offset map,
// channel limit and bus FSM state type.
package riscv_stream_pkg;

    localparam logic [8:0] OFS_DATA   = 9'h000;
    localparam logic [8:0] OFS_STATUS = 9'h100;
    localparam int         MAX_CH     = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } bridge_state_e;

endpackage

// File: rtl/stream_out_fifo.sv
// First-word fall-through FIFO for one outbound stream channel; head reads
// as zero while empty so stale entries never appear on the stream.
module stream_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    // Push is judged on the registered count only, so a pop on a full FIFO
    // does not make room for a push in the same cycle.
    always_comb begin
        do_push  = push && (count_q < CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/riscv_stream_bridge.sv
// Memory-mapped bridge between the PicoRV32 native bus and NUM_CH outbound
// FIFO / inbound holding-register stream channels with blocking accesses.
module riscv_stream_bridge
    import riscv_stream_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 5,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_valid,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [3:0]                   mem_wstrb,
    output logic                         mem_ready,
    output logic [31:0]                  mem_rdata,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]            val_out,
    input  logic [NUM_CH-1:0]            ready_downward,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]            val_in,
    output logic [NUM_CH-1:0]            ready_upward
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]     fifo_full, fifo_empty, push_vec, pop_in_vec;
    logic [CW-1:0]         fifo_count [NUM_CH];
    logic [NUM_CH-1:0]     in_valid_q, in_valid_d;
    logic [DATA_WIDTH-1:0] in_data_q [NUM_CH];
    logic [DATA_WIDTH-1:0] in_data_d [NUM_CH];

    bridge_state_e state_q, state_d;
    logic          mem_ready_q, mem_ready_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic                  sel, is_store, data_hit, status_hit, fire;
    logic [8:0]            ofs;
    logic                  ch_can_push, ch_has_in;
    logic [DATA_WIDTH-1:0] ch_data;
    logic [31:0]           status_word;
    logic                  access_ok;
    logic [31:0]           access_rdata;

    assign sel        = mem_valid && (mem_addr[31:9] == BASE_ADDR[31:9]);
    assign ofs        = mem_addr[8:0];
    assign is_store   = |mem_wstrb;
    assign data_hit   = (ofs[8] == OFS_DATA[8]) && (ofs[1:0] == OFS_DATA[1:0]) &&
                        (32'(ofs[7:2]) < NUM_CH);
    assign status_hit = (ofs == OFS_STATUS);

    always_comb begin
        ch_can_push = 1'b0;
        ch_has_in   = 1'b0;
        ch_data     = '0;
        status_word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(ofs[7:2]) == c) begin
                ch_can_push = (fifo_count[c] < CW'(DEPTH));
                ch_has_in   = in_valid_q[c];
                ch_data     = in_data_q[c];
            end
            status_word[c]          = ~fifo_full[c];
            status_word[MAX_CH + c] = in_valid_q[c];
        end
    end

    // Unmapped offsets and STATUS always complete; only live data slots block.
    always_comb begin
        access_ok    = 1'b1;
        access_rdata = '0;
        if (data_hit) begin
            if (is_store) begin
                access_ok = ch_can_push;
            end else begin
                access_ok    = ch_has_in;
                access_rdata = ch_data;
            end
        end else if (status_hit && !is_store) begin
            access_rdata = status_word;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = '0;
        fire        = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (access_ok) begin
                    fire        = 1'b1;
                    state_d     = ACK;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = access_rdata;
                end else begin
                    state_d = WAIT;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            push_vec[c]   = fire && data_hit && is_store && (32'(ofs[7:2]) == c);
            pop_in_vec[c] = fire && data_hit && !is_store && (32'(ofs[7:2]) == c);
            in_valid_d[c] = in_valid_q[c];
            in_data_d[c]  = in_data_q[c];
            if (pop_in_vec[c]) begin
                in_valid_d[c] = 1'b0;
            end
            if (val_in[c] && !in_valid_q[c]) begin
                in_valid_d[c] = 1'b1;
                in_data_d[c]  = din[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_q <= '0;
            in_data_q  <= '{default: '0};
        end else begin
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
        end
    end

    assign ready_upward = reset ? '0 : ~in_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stream_out_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (reset),
            .push     (push_vec[g]),
            .push_data(mem_wdata),
            .pop      (ready_downward[g]),
            .head     (dout[g*DATA_WIDTH +: DATA_WIDTH]),
            .count    (fifo_count[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
        assign val_out[g] = ~fifo_empty[g];
    end

endmodule

// File: tb/tb_riscv_stream_bridge.sv
// Self-checking bench for riscv_stream_bridge: directed vectors, multi-cycle
// corner sequences and a randomized run against a queue-based channel model.
module tb_riscv_stream_bridge;

    localparam int          NCH  = 5;
    localparam int          DEP  = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_valid;
    logic [31:0]       mem_addr, mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NCH*DW-1:0] dout, din;
    logic [NCH-1:0]    val_out, ready_downward, val_in, ready_upward;

    always #5 clk = ~clk;

    riscv_stream_bridge #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .DEPTH     (DEP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .dout          (dout),
        .val_out       (val_out),
        .ready_downward(ready_downward),
        .din           (din),
        .val_in        (val_in),
        .ready_upward  (ready_upward)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit rand_en = 1'b0;

    // Channel model: words accepted but not yet drained, and inbound holding state.
    logic [31:0] q [NCH][$];
    bit          mv [NCH];
    logic [31:0] md [NCH];
    int          pre_size [NCH];
    int          req_size [NCH];
    bit          pre_mv [NCH];
    bit          req_mv [NCH];
    logic [31:0] exp_status_pre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_status_pre = '0;
        for (int c = 0; c < NCH; c++) begin
            pre_size[c] = q[c].size();
            pre_mv[c]   = mv[c];
            exp_status_pre[c]      = (q[c].size() < DEP);
            exp_status_pre[16 + c] = mv[c];
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("mon val_out[%0d]", c), 32'(val_out[c]), 32'(q[c].size() != 0));
            if (val_out[c] && ready_downward[c] && q[c].size() != 0) begin
                check($sformatf("mon dout[%0d]", c), dout[32*c +: 32], q[c][0]);
                void'(q[c].pop_front());
            end
            check($sformatf("mon ready_upward[%0d]", c), 32'(ready_upward[c]), 32'(!mv[c]));
            if (val_in[c] && !mv[c]) begin
                mv[c] = 1'b1;
                md[c] = din[32*c +: 32];
            end
        end
    endtask

    task automatic drive_rand();
        ready_downward = NCH'($urandom);
        for (int c = 0; c < NCH; c++) begin
            val_in[c]       = ($urandom_range(0, 3) == 0);
            din[32*c +: 32] = $urandom;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        if (rand_en) drive_rand();
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
    endtask

    task automatic wait_ack(input int budget, output logic ok, output logic [31:0] rd,
                            output int cyc);
        ok  = 1'b0;
        rd  = '0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            tick();
            if (cyc == 0) begin
                req_size = pre_size;
                req_mv   = pre_mv;
            end
            cyc++;
            if (mem_ready) begin
                ok = 1'b1;
                rd = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int budget, output logic ok, output logic [31:0] rd,
                          output int cyc);
        start_req(a, d, s);
        wait_ack(budget, ok, rd, cyc);
    endtask

    vec_t        vecs [9];
    logic        ok;
    logic [31:0] rd, d;
    logic [3:0]  s;
    int          cyc, op, c, hits;

    initial begin
        vecs[0] = '{BASE + 32'h100, 32'h0,         4'h0, 32'h0000_001F};
        vecs[1] = '{BASE + 32'h1F0, 32'h0,         4'h0, 32'h0};
        vecs[2] = '{BASE + 32'h03C, 32'hCAFE_0001, 4'hF, 32'h0};
        vecs[3] = '{BASE + 32'h014, 32'h0,         4'h0, 32'h0};
        vecs[4] = '{BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[5] = '{BASE + 32'h104, 32'h0,         4'h0, 32'h0};
        vecs[6] = '{BASE + 32'h002, 32'h0,         4'h0, 32'h0};
        vecs[7] = '{BASE + 32'h014, 32'h1234_0000, 4'h1, 32'h0};
        vecs[8] = '{BASE + 32'h100, 32'h0,         4'h0, 32'h0000_001F};

        reset = 1'b1;
        mem_valid = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        ready_downward = '0;
        din = '0;
        val_in = '0;

        #1;
        check("reset mem_ready", 32'(mem_ready), 32'd0);
        check("reset mem_rdata", mem_rdata, 32'd0);
        check("reset val_out", 32'(val_out), 32'd0);
        check("reset dout ch0", dout[31:0], 32'd0);
        check("reset ready_upward", 32'(ready_upward), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("post-reset ready_upward", 32'(ready_upward), 32'h1F);

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 4, ok, rd, cyc);
            check($sformatf("vec%0d latency", i), 32'(cyc), 32'd1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d val_out", i), 32'(val_out), 32'd0);
            tick();
        end

        start_req(32'h1000_0100, 32'h0, 4'h0);
        hits = 0;
        repeat (5) begin
            tick();
            if (mem_ready) hits++;
        end
        check("outside window no ack", 32'(hits), 32'd0);
        mem_valid = 1'b0;
        tick();

        ready_downward = 5'b00100;
        access(BASE + 32'h008, 32'hDEAD_BEEF, 4'hF, 4, ok, rd, cyc);
        check("ch2 store latency", 32'(cyc), 32'd1);
        check("ch2 val_out after push", 32'(val_out), 32'h04);
        check("ch2 dout", dout[95:64], 32'hDEAD_BEEF);
        tick();
        check("ch2 val_out one cycle", 32'(val_out), 32'd0);
        ready_downward = '0;

        for (int k = 1; k <= 4; k++) begin
            access(BASE, 32'(k), 4'hF, 4, ok, rd, cyc);
            check($sformatf("ch0 store%0d latency", k), 32'(cyc), 32'd1);
            tick();
        end
        start_req(BASE, 32'd5, 4'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ch0 fifth store stalled", 32'(mem_ready), 32'd0);
        end
        check("ch0 head before pulse", dout[31:0], 32'd1);
        ready_downward[0] = 1'b1;
        tick();
        ready_downward[0] = 1'b0;
        check("ch0 pop does not admit push same cycle", 32'(mem_ready), 32'd0);
        wait_ack(6, ok, rd, cyc);
        check("ch0 fifth store acked", 32'(ok), 32'd1);
        tick();
        ready_downward[0] = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("ch0 drain%0d valid", k), 32'(val_out[0]), 32'd1);
            check($sformatf("ch0 drain%0d data", k), dout[31:0], 32'(k));
            tick();
        end
        check("ch0 drained", 32'(val_out[0]), 32'd0);
        ready_downward = '0;

        start_req(BASE + 32'h004, 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ch1 load stalled", 32'(mem_ready), 32'd0);
        end
        val_in[1] = 1'b1;
        din[63:32] = 32'h1234_5678;
        tick();
        val_in = '0;
        din = '0;
        check("ch1 captured", 32'(ready_upward[1]), 32'd0);
        wait_ack(4, ok, rd, cyc);
        check("ch1 load acked", 32'(ok), 32'd1);
        check("ch1 load data", rd, 32'h1234_5678);
        check("ch1 ready_upward restored", 32'(ready_upward[1]), 32'd1);
        tick();

        val_in[3] = 1'b1;
        din[127:96] = 32'hA5A5_0003;
        tick();
        val_in = '0;
        din = '0;
        for (int k = 0; k < 4; k++) begin
            access(BASE, 32'h100 + 32'(k), 4'hF, 4, ok, rd, cyc);
            tick();
        end
        access(BASE + 32'h100, 32'h0, 4'h0, 4, ok, rd, cyc);
        check("status loaded", rd, 32'h0008_001E);
        tick();

        start_req(BASE, 32'h99, 4'hF);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("full-fifo store stalled", 32'(mem_ready), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("mid-access reset val_out", 32'(val_out), 32'd0);
        check("mid-access reset dout ch0", dout[31:0], 32'd0);
        check("mid-access reset ready_upward", 32'(ready_upward), 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = '0;
        hits = 0;
        repeat (2) begin
            tick();
            if (mem_ready) hits++;
        end
        check("mid-access reset no mem_ready", 32'(hits), 32'd0);
        reset = 1'b0;
        #1;
        check("release ready_upward", 32'(ready_upward), 32'h1F);
        tick();
        access(BASE + 32'h100, 32'h0, 4'h0, 4, ok, rd, cyc);
        check("status after abort", rd, 32'h0000_001F);
        tick();

        for (int k = 0; k < NCH; k++) begin
            q[k].delete();
            mv[k] = 1'b0;
            md[k] = '0;
        end
        mon_en = 1'b1;
        rand_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            c  = $urandom_range(0, NCH - 1);
            if (op < 5) begin
                d = $urandom;
                s = 4'($urandom_range(1, 15));
                access(BASE + 32'(4 * c), d, s, 100, ok, rd, cyc);
                check("rand store acked", 32'(ok), 32'd1);
                check("rand store first-cycle ack", 32'(cyc == 1), 32'(req_size[c] < DEP));
                check("rand store rdata", rd, 32'd0);
                if (ok) q[c].push_back(d);
            end else if (op < 8) begin
                access(BASE + 32'(4 * c), 32'h0, 4'h0, 100, ok, rd, cyc);
                check("rand load acked", 32'(ok), 32'd1);
                check("rand load first-cycle ack", 32'(cyc == 1), 32'(req_mv[c]));
                check("rand load data", rd, md[c]);
                if (ok) mv[c] = 1'b0;
            end else begin
                access(BASE + 32'h100, 32'h0, 4'h0, 4, ok, rd, cyc);
                check("rand status", rd, exp_status_pre);
            end
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
        mon_en = 1'b0;
        rand_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_stream_bridge.md
# riscv_stream_bridge

Parametrised memory-mapped stream I/O bridge between the PicoRV32 native memory bus and NUM_CH outbound/inbound 32-bit latency-insensitive stream channels. Replaces the fixed five-port output/input arrangement around the soft core with one block: per-channel output FIFOs of configurable depth, per-channel input holding registers, blocking load/store semantics and a status register. Sits beside `picorv_mem` on the CPU bus and decodes its own address window.

## Interface
- DATA_WIDTH, 32: stream word width; fixed at the bus width, 32.
- NUM_CH, 5: number of channels in each direction; legal range 1..16.
- DEPTH, 4: entries per output FIFO; power of two, at least 2.
- BASE_ADDR, 32'h2000_0000: base of the 512-byte window.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_valid  in  1  CPU bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  nonzero means store, zero means load.
- mem_ready  out  1  one-cycle acknowledge; registered.
- mem_rdata  out  32  load data; valid while mem_ready is high.
- dout  out  NUM_CH*32  outbound data; channel c occupies bits [32c+31:32c].
- val_out  out  NUM_CH  outbound valid per channel.
- ready_downward  in  NUM_CH  consumer ready per channel.
- din  in  NUM_CH*32  inbound data, same packing as dout.
- val_in  in  NUM_CH  inbound valid per channel.
- ready_upward  out  NUM_CH  inbound ready per channel.

## Operation
- The block is selected when mem_valid is high and mem_addr[31:9] equals BASE_ADDR[31:9]. Outside the window the block never asserts mem_ready.
- Offset map, with offsets taken as mem_addr[8:0]:
  - 0x000 + 4c: DATA_c. A store pushes mem_wdata into output FIFO c. A load pops input register c.
  - 0x100: STATUS, read-only. Bits [15:0] are the output not-full flags; bits [NUM_CH+15:16] are the input-valid flags. Unused bits read as 0.
  - Any other offset, and any channel c ≥ NUM_CH: a store is dropped and a load returns 0. Both are acknowledged without stalling.
- Partial mem_wstrb is treated as a full-word store.
- FSM states are IDLE, WAIT and ACK.
  - IDLE → ACK when the access can complete this cycle. That is: a store with FIFO c not full, a load with input register c full, or a STATUS/unmapped access. The push or pop happens on this cycle.
  - IDLE → WAIT when the access is blocked.
  - WAIT → ACK on the cycle the blocking condition clears. The push or pop happens then.
  - ACK → IDLE unconditionally. mem_ready is high in ACK only.
- Output FIFO is first-word fall-through.
  - val_out[c] equals not-empty; dout carries the head entry.
  - Pop when val_out[c] and ready_downward[c] are both high.
  - A push is allowed only when the registered count is below DEPTH. When full, a pop and a blocked push in the same cycle complete the pop only; the push completes on the next cycle.
- Input register: ready_upward[c] equals not-full while reset is low, and is forced to 0 while reset is high. Capture when val_in[c] and ready_upward[c] are both high. A CPU pop frees the register at the clock edge; new data can be captured from the following cycle.
- A reset mid-access aborts the access: no mem_ready is issued, FIFOs and registers are emptied, and the FSM returns to IDLE.

## Timing
- Reset values: mem_ready 0, mem_rdata 0, val_out 0, dout 0, ready_upward 0 while asserted. After release, ready_upward is all ones.
- Non-blocked access: request seen at cycle T, mem_ready and mem_rdata at T+1. The CPU drops mem_valid at T+2, when the FSM is back in IDLE, so no access is accepted twice.
- Store-to-val_out latency: val_out rises on the cycle after the push edge, at T+1.
- Back-to-back bus accesses: one access every 2 cycles minimum.
- Inbound: capture at edge E. STATUS bit and load data are visible from E; ready_upward falls at E.
- Under full throughput each output channel sustains 1 word per 2 CPU cycles. The downstream drain sustains 1 word per cycle.

## Structure
- Package `riscv_stream_pkg` holds:
  - OFS_DATA = 9'h000, OFS_STATUS = 9'h100.
  - The FSM state enum (IDLE, WAIT, ACK).
  - MAX_CH = 16.
- Sub-module `stream_out_fifo`, parameters DATA_WIDTH and DEPTH: first-word fall-through, with count, full and empty outputs. Instantiated NUM_CH times in a generate loop.
- Input registers and the FSM are inline in the top module.

## Test plan
- Store 0xDEADBEEF to BASE+0x008 with ready_downward[2]=1 → mem_ready at T+1; val_out[2]=1 with dout[95:64]=0xDEADBEEF for exactly one cycle; other channels stay idle.
- With DEPTH=4 and ready_downward[0]=0: issue 5 stores to channel 0 → the fifth stalls with mem_ready low. Raising ready_downward for one cycle → the fifth acknowledges; words drain in order 1..5.
- Load from BASE+0x004 with channel 1 empty → stall. Drive val_in[1]=1 with 0x12345678 for one cycle → mem_rdata=0x12345678 with mem_ready; ready_upward[1] returns high afterwards.
- Load STATUS after reset with NUM_CH=5 → 0x0000001F. After one inbound word on channel 3 and four stores to channel 0 with no drain → 0x0008001E.
- Store to BASE+0x03C with NUM_CH=5 → acknowledged, no val_out change. Load from BASE+0x1F0 → returns 0.
- Assert reset while a store is stalled on a full FIFO → mem_ready never pulses; val_out goes to 0 immediately; ready_upward is 0 during reset and all ones after release.
